// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled stepping of static, bounce, binary-count and
// blink patterns, with registered LED outputs and a per-step strobe.
module led_pattern_gen #(
   parameter int         N_LEDS       = 8,
   parameter int         DIV_W        = 24,
   parameter int         DEFAULT_DIV  = 12500000,
   parameter logic [1:0] DEFAULT_MODE = 2'd1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              load,
   input  logic [1:0]        mode,
   input  logic [DIV_W-1:0]  div,
   input  logic [N_LEDS-1:0] static_val,
   output logic [N_LEDS-1:0] y,
   output logic              step_stb
);

   localparam int                POS_W      = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
   localparam logic [POS_W-1:0]  POS_LAST   = POS_W'(N_LEDS - 1);
   localparam logic [POS_W-1:0]  POS_PENULT = POS_W'((N_LEDS > 1) ? (N_LEDS - 2) : 0);
   localparam logic [N_LEDS-1:0] LED0       = N_LEDS'(1);

   typedef enum logic [1:0] {
      MODE_STATIC = 2'd0,
      MODE_BOUNCE = 2'd1,
      MODE_COUNT  = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_e;

   mode_e             mode_r;
   logic [DIV_W-1:0]  div_r;
   logic [DIV_W-1:0]  presc_r;
   logic [POS_W-1:0]  pos_r;
   logic              dir_down_r;
   logic [N_LEDS-1:0] cnt_r;
   logic              phase_r;
   logic [N_LEDS-1:0] y_r;
   logic              step_stb_r;

   logic              tick_s;
   logic [POS_W-1:0]  next_pos_s;
   logic              next_dir_down_s;
   logic [N_LEDS-1:0] y_next_s;

   assign tick_s   = (presc_r == div_r);
   assign y        = y_r;
   assign step_stb = step_stb_r;

   // Bounce successor: reverse at either end instead of stepping past it.
   always_comb begin
      next_pos_s      = pos_r;
      next_dir_down_s = dir_down_r;
      if (N_LEDS == 1) begin
         next_pos_s      = '0;
         next_dir_down_s = 1'b0;
      end else if (!dir_down_r) begin
         if (pos_r == POS_LAST) begin
            next_pos_s      = POS_PENULT;
            next_dir_down_s = 1'b1;
         end else begin
            next_pos_s      = pos_r + POS_W'(1);
            next_dir_down_s = 1'b0;
         end
      end else begin
         if (pos_r == '0) begin
            next_pos_s      = POS_W'(1);
            next_dir_down_s = 1'b0;
         end else begin
            next_pos_s      = pos_r - POS_W'(1);
            next_dir_down_s = 1'b1;
         end
      end
   end

   // LED image of the current pattern state, registered into y_r below.
   always_comb begin
      y_next_s = '0;
      case (mode_r)
         MODE_STATIC: y_next_s = static_val;
         MODE_BOUNCE: y_next_s = LED0 << pos_r;
         MODE_COUNT:  y_next_s = cnt_r;
         MODE_BLINK:  y_next_s = phase_r ? {N_LEDS{1'b1}} : {N_LEDS{1'b0}};
         default:     y_next_s = '0;
      endcase
   end

   // Configuration, prescaler, pattern state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_r     <= mode_e'(DEFAULT_MODE);
         div_r      <= DIV_W'(DEFAULT_DIV);
         presc_r    <= '0;
         pos_r      <= '0;
         dir_down_r <= 1'b0;
         cnt_r      <= '0;
         phase_r    <= 1'b1;
         y_r        <= '0;
         step_stb_r <= 1'b0;
      end else begin
         // A load wins over a coincident tick so the restarted pattern never skips its first state.
         if (load) begin
            mode_r     <= mode_e'(mode);
            div_r      <= div;
            presc_r    <= '0;
            pos_r      <= '0;
            dir_down_r <= 1'b0;
            cnt_r      <= '0;
            phase_r    <= 1'b1;
            step_stb_r <= 1'b0;
         end else if (en) begin
            if (tick_s) begin
               presc_r    <= '0;
               step_stb_r <= 1'b1;
               case (mode_r)
                  MODE_STATIC: begin
                  end
                  MODE_BOUNCE: begin
                     pos_r      <= next_pos_s;
                     dir_down_r <= next_dir_down_s;
                  end
                  MODE_COUNT:  cnt_r   <= cnt_r + N_LEDS'(1);
                  MODE_BLINK:  phase_r <= ~phase_r;
                  default: begin
                  end
               endcase
            end else begin
               presc_r    <= presc_r + DIV_W'(1);
               step_stb_r <= 1'b0;
            end
         end else begin
            step_stb_r <= 1'b0;
         end
         y_r <= y_next_s;
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: a step-count reference model predicts
// {step_stb, y} every cycle and a negedge monitor compares against the DUT.
module tb_led_pattern_gen;

   localparam int         N     = 4;
   localparam int         DW    = 8;
   localparam int         DDIV  = 3;
   localparam logic [1:0] DMODE = 2'd1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          load;
   logic [1:0]    mode;
   logic [DW-1:0] div;
   logic [N-1:0]  static_val;
   logic [N-1:0]  y;
   logic          step_stb;

   int checks = 0;
   int errors = 0;

   logic [N:0] exp_q[$];

   // Reference state: configuration, prescaler count and steps taken since restart.
   int m_mode;
   int m_div;
   int m_presc;
   int m_k;

   led_pattern_gen #(
      .N_LEDS(N), .DIV_W(DW), .DEFAULT_DIV(DDIV), .DEFAULT_MODE(DMODE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .mode(mode), .div(div),
      .static_val(static_val), .y(y), .step_stb(step_stb)
   );

   always #5 clk = ~clk;

   // Pattern as a function of how many steps were taken since the last restart.
   function automatic logic [N-1:0] pattern(int md, int k, logic [N-1:0] sv);
      logic [N-1:0] r;
      int p;
      int m;
      int pos;
      r = '0;
      if (md == 0) begin
         r = sv;
      end else if (md == 1) begin
         if (N == 1) begin
            r = N'(1);
         end else begin
            p   = 2 * (N - 1);
            m   = k % p;
            pos = (m < N) ? m : (p - m);
            r   = N'(1) << pos;
         end
      end else if (md == 2) begin
         r = N'(k % (1 << N));
      end else begin
         r = ((k % 2) == 0) ? {N{1'b1}} : {N{1'b0}};
      end
      return r;
   endfunction

   // Reference model: predict the outputs produced by each rising edge.
   initial begin
      logic         tick;
      logic [N-1:0] e_y;
      logic         e_stb;
      m_mode  = int'(DMODE);
      m_div   = DDIV;
      m_presc = 0;
      m_k     = 0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_mode  = int'(DMODE);
            m_div   = DDIV;
            m_presc = 0;
            m_k     = 0;
            exp_q.push_back({1'b0, {N{1'b0}}});
         end else begin
            tick  = (m_presc == m_div);
            e_y   = pattern(m_mode, m_k, static_val);
            e_stb = !load && en && tick;
            if (load) begin
               m_mode  = int'(mode);
               m_div   = int'(div);
               m_presc = 0;
               m_k     = 0;
            end else if (en) begin
               if (tick) begin
                  m_presc = 0;
                  m_k     = m_k + 1;
               end else begin
                  m_presc = m_presc + 1;
               end
            end
            exp_q.push_back({e_stb, e_y});
         end
      end
   end

   // Monitor: compare DUT outputs with the oldest prediction, away from the clock edge.
   initial begin
      logic [N:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: no prediction at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            if (!rst_n) e = '0;
            checks += 2;
            if (y !== e[N-1:0]) begin
               errors++;
               $display("FAIL y: got %b expected %b at %0t", y, e[N-1:0], $time);
            end
            if (step_stb !== e[N]) begin
               errors++;
               $display("FAIL step_stb: got %b expected %b at %0t", step_stb, e[N], $time);
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run(int n);
      repeat (n) next_cycle();
   endtask

   task automatic do_load(logic [1:0] md, logic [DW-1:0] dv);
      load = 1'b1;
      mode = md;
      div  = dv;
      next_cycle();
      load = 1'b0;
   endtask

   initial begin
      int i;
      rst_n      = 1'b0;
      en         = 1'b0;
      load       = 1'b0;
      mode       = 2'd0;
      div        = '0;
      static_val = '0;
      run(3);
      rst_n = 1'b1;

      // Default configuration straight out of reset.
      en = 1'b1;
      run(20);

      // Bounce with period 3.
      do_load(2'd1, 8'd2);
      run(30);

      // Binary count every cycle, through the wrap.
      do_load(2'd2, 8'd0);
      run(20);

      // Blink with a freeze in the middle.
      do_load(2'd3, 8'd1);
      run(7);
      en = 1'b0;
      run(5);
      en = 1'b1;
      run(8);

      // Load landing exactly on a tick.
      do_load(2'd2, 8'd1);
      i = 0;
      while (!(m_presc == m_div) && i < 10) begin
         next_cycle();
         i++;
      end
      checks++;
      if (i >= 10) begin
         errors++;
         $display("FAIL tick_align: no tick within %0d cycles", i);
      end
      do_load(2'd1, 8'd3);
      run(12);

      // Static mode follows the live input with one cycle latency.
      do_load(2'd0, 8'd0);
      static_val = 4'hA;
      run(2);
      static_val = 4'h5;
      run(2);
      static_val = 4'h3;
      en = 1'b0;
      run(2);
      en = 1'b1;
      static_val = 4'hC;
      run(2);

      // Asynchronous reset in the middle of counting.
      do_load(2'd2, 8'd0);
      i = 0;
      while ((m_k % 16) != 9 && i < 40) begin
         next_cycle();
         i++;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (y !== '0 || step_stb !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got y=%b stb=%b expected y=0000 stb=0", y, step_stb);
      end
      run(2);
      rst_n = 1'b1;
      run(8);

      // Randomised operation.
      for (int c = 0; c < 400; c++) begin
         load       = ($urandom_range(0, 19) == 0);
         mode       = 2'($urandom_range(0, 3));
         div        = DW'($urandom_range(0, 3));
         en         = ($urandom_range(0, 4) != 0);
         static_val = N'($urandom);
         next_cycle();
      end
      load = 1'b0;
      run(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
